audio_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 32-bit on-chip program/sample RAM between the Nios II data master (port 0) and the audio sample DMA (port 1). It drives the RAM's address, byteenable, chipselect, write and writedata, and returns readdata to whichever port issued the read. The DMA has priority for real-time audio, and a starvation counter bounds CPU latency. It sits between the Avalon fabric and the RAM instance in the audio_nios system.

---
 rtl/audio_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_audio_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : audio_mem_arbiter
// Brief    : Two-port arbiter for the single-port 32-bit program/sample RAM.
//            Port 0 is the Nios II data master and port 1 is the audio sample
//            DMA. The DMA has priority, and a run counter bounds how long the
//            CPU can be held off. Read responses are tagged with the issuing
//            port and return one cycle after acceptance.
// Options  : `define AUDIO_MEM_ARB_RANGE_CHECK_EN to block RAM access for
//            addresses >= DEPTH. Such reads still complete, returning zero.
// Revision : 1.0 - initial release
// ============================================================================
module audio_mem_arbiter #(
    parameter int ADDR_W      = 17,
    parameter int DEPTH       = 80000,
    parameter int DMA_RUN_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    // Port 0: CPU data master
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [3:0]        m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,
    // Port 1: audio sample DMA
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [3:0]        m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,
    // RAM side
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata
);

    localparam logic [3:0] c_RUN_MAX = 4'(DMA_RUN_MAX);

    // Registered state
    logic [3:0]        r_run_cnt;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_rd_pend;
    logic              r_rd_port;

    // Combinational grant and mux results
    logic              w_m0_req;
    logic              w_m1_req;
    logic              w_gnt_dma;
    logic              w_gnt_cpu;
    logic              w_gnt_any;
    logic              w_gnt_rd;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_sel_read;
    logic              w_sel_write;
    logic              w_in_range;
    logic [31:0]       w_rd_data;

    // Arbitration: DMA wins unless the CPU has already waited DMA_RUN_MAX grants
    always_comb begin
        w_m0_req    = m0_read | m0_write;
        w_m1_req    = m1_read | m1_write;
        w_gnt_dma   = !reset && w_m1_req && (!w_m0_req || (r_run_cnt != c_RUN_MAX));
        w_gnt_cpu   = !reset && w_m0_req && !w_gnt_dma;
        w_gnt_any   = w_gnt_dma | w_gnt_cpu;
        w_sel_addr  = w_gnt_dma ? m1_address : m0_address;
        w_sel_read  = w_gnt_dma ? m1_read    : m0_read;
        w_sel_write = w_gnt_dma ? m1_write   : m0_write;
        // Write wins when both strobes are high, so a read needs write low
        w_gnt_rd    = w_gnt_any && w_sel_read && !w_sel_write;
    end

`ifdef AUDIO_MEM_ARB_RANGE_CHECK_EN
    logic r_rd_zero;

    // Range qualifier: zero-extend so the compare is safe for any ADDR_W
    always_comb begin
        w_in_range = (64'(w_sel_addr) < 64'(DEPTH));
    end

    // Remember whether the outstanding read was out of range so it returns zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_zero <= 1'b0;
        end else begin
            r_rd_zero <= w_gnt_rd && !w_in_range;
        end
    end

    // Out-of-range reads never touched the RAM, so their data is forced to zero
    always_comb begin
        w_rd_data = r_rd_zero ? 32'h0 : mem_readdata;
    end
`else
    // Without range checking every granted address reaches the RAM
    always_comb begin
        w_in_range = 1'b1;
        w_rd_data  = mem_readdata;
    end
`endif

    // RAM command: address holds its last value on idle cycles
    always_comb begin
        mem_chipselect = w_gnt_any && w_in_range;
        mem_write      = mem_chipselect && w_sel_write;
        mem_address    = w_gnt_any ? w_sel_addr : r_last_addr;
        mem_byteenable = w_gnt_dma ? m1_byteenable : m0_byteenable;
        mem_writedata  = w_gnt_dma ? m1_writedata  : m0_writedata;
    end

    // Port handshake and tagged read response
    always_comb begin
        m0_waitrequest   = reset || (w_m0_req && !w_gnt_cpu);
        m1_waitrequest   = reset || (w_m1_req && !w_gnt_dma);
        m0_readdatavalid = r_rd_pend && !r_rd_port;
        m1_readdatavalid = r_rd_pend &&  r_rd_port;
        m0_readdata      = w_rd_data;
        m1_readdata      = w_rd_data;
    end

    // DMA run counter: counts DMA grants that held off a waiting CPU
    always_ff @(posedge clk) begin
        if (reset) begin
            r_run_cnt <= 4'd0;
        end else if (!w_m0_req || w_gnt_cpu) begin
            r_run_cnt <= 4'd0;
        end else if (w_gnt_dma && (r_run_cnt != c_RUN_MAX)) begin
            r_run_cnt <= r_run_cnt + 4'd1;
        end
    end

    // Last granted address, replayed on idle cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_addr <= '0;
        end else if (w_gnt_any) begin
            r_last_addr <= w_sel_addr;
        end
    end

    // Read tag pipeline: one-cycle pending flag plus the issuing port index
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pend <= 1'b0;
            r_rd_port <= 1'b0;
        end else begin
            r_rd_pend <= w_gnt_rd;
            if (w_gnt_rd) begin
                r_rd_port <= w_gnt_dma;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_mem_arbiter
// Brief    : Directed self-checking bench for audio_mem_arbiter with a small
//            behavioural RAM (registered address, unregistered data).
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_mem_arbiter;

    localparam int ADDR_W = 17;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic [3:0]        m0_byteenable, m1_byteenable;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [31:0]       m0_writedata, m1_writedata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [31:0]       m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect, mem_write;
    logic [31:0]       mem_writedata, mem_readdata;

    int n_checks = 0;
    int n_fails  = 0;

    audio_mem_arbiter #(.ADDR_W(ADDR_W), .DEPTH(80000), .DMA_RUN_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: 256 words indexed by the low address byte
    logic [31:0] ram [0:255];
    logic [7:0]  ram_raddr;

    always @(posedge clk) begin
        if (reset) begin
            ram[16]   <= 32'hDEADBEEF;
            ram[5]    <= 32'h05050505;
            ram[6]    <= 32'h06060606;
            ram[7]    <= 32'hAAAABBBB;
            ram[128]  <= 32'h0;
            ram_raddr <= 8'd0;
        end else if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address[7:0]][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end else begin
                ram_raddr <= mem_address[7:0];
            end
        end
    end

    assign mem_readdata = ram[ram_raddr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_address = '0; m1_address = '0;
        m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        m0_writedata = '0; m1_writedata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] exp_dma_seq;
    logic [4:0] exp_dma_seq2;
    logic       exp_cs_oor;
    logic [31:0] exp_oor_data;

    initial begin
        exp_dma_seq  = 10'b1111011110;
        exp_dma_seq2 = 5'b11110;
`ifdef AUDIO_MEM_ARB_RANGE_CHECK_EN
        exp_cs_oor   = 1'b0;
        exp_oor_data = 32'h0;
`else
        exp_cs_oor   = 1'b1;
        exp_oor_data = 32'h12345678;
`endif
        // Reset with both ports requesting
        idle();
        reset = 1;
        m0_read = 1; m1_read = 1;
        @(negedge clk);
        check("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
        check("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
        check("rst_cs", 32'(mem_chipselect), 32'd0);
        step();
        step();
        reset = 0;
        idle();
        @(negedge clk);
        check("post_rst_m0_rdv", 32'(m0_readdatavalid), 32'd0);
        check("post_rst_m1_rdv", 32'(m1_readdatavalid), 32'd0);
        check("post_rst_cs", 32'(mem_chipselect), 32'd0);
        check("post_rst_wr", 32'(mem_write), 32'd0);
        check("post_rst_addr", 32'(mem_address), 32'd0);

        // CPU-only read of word 0x10
        step();
        m0_read = 1; m0_address = 17'h10;
        @(negedge clk);
        check("cpu_rd_wait", 32'(m0_waitrequest), 32'd0);
        check("cpu_rd_cs", 32'(mem_chipselect), 32'd1);
        check("cpu_rd_addr", 32'(mem_address), 32'h10);
        step();
        idle();
        @(negedge clk);
        check("cpu_rd_rdv", 32'(m0_readdatavalid), 32'd1);
        check("cpu_rd_data", m0_readdata, 32'hDEADBEEF);
        check("cpu_rd_m1_rdv", 32'(m1_readdatavalid), 32'd0);
        check("idle_addr_hold", 32'(mem_address), 32'h10);
        check("idle_cs", 32'(mem_chipselect), 32'd0);

        // Alternating reads: DMA addr 5 then CPU addr 6
        step();
        m1_read = 1; m1_address = 17'd5;
        @(negedge clk);
        check("alt_m1_wait", 32'(m1_waitrequest), 32'd0);
        step();
        idle();
        m0_read = 1; m0_address = 17'd6;
        @(negedge clk);
        check("alt_m0_wait", 32'(m0_waitrequest), 32'd0);
        check("alt_m1_rdv", 32'(m1_readdatavalid), 32'd1);
        check("alt_m1_data", m1_readdata, 32'h05050505);
        check("alt_m0_rdv_early", 32'(m0_readdatavalid), 32'd0);
        step();
        idle();
        @(negedge clk);
        check("alt_m0_rdv", 32'(m0_readdatavalid), 32'd1);
        check("alt_m0_data", m0_readdata, 32'h06060606);
        check("alt_m1_rdv_late", 32'(m1_readdatavalid), 32'd0);

        // Byte-enable write then read back
        step();
        m0_write = 1; m0_address = 17'd7; m0_writedata = 32'h11223344; m0_byteenable = 4'b0101;
        @(negedge clk);
        check("be_wr_wait", 32'(m0_waitrequest), 32'd0);
        check("be_wr_memwr", 32'(mem_write), 32'd1);
        check("be_wr_be", 32'(mem_byteenable), 32'h5);
        step();
        idle();
        m0_read = 1; m0_address = 17'd7;
        @(negedge clk);
        check("be_wr_no_rdv", 32'(m0_readdatavalid), 32'd0);
        step();
        idle();
        @(negedge clk);
        check("be_rd_rdv", 32'(m0_readdatavalid), 32'd1);
        check("be_rd_data", m0_readdata, 32'hAA22BB44);

        // Continuous contention: expect D,D,D,D,C,D,D,D,D,C
        step();
        m0_read = 1; m0_address = 17'h10;
        m1_read = 1; m1_address = 17'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("cont_m1_wait_%0d", i), 32'(m1_waitrequest), 32'(!exp_dma_seq[9-i]));
            check($sformatf("cont_m0_wait_%0d", i), 32'(m0_waitrequest), 32'(exp_dma_seq[9-i]));
            step();
        end
        idle();
        step();

        // Out-of-range write then read at address 80000
        m0_write = 1; m0_address = 17'd80000; m0_writedata = 32'h12345678;
        @(negedge clk);
        check("oor_wr_wait", 32'(m0_waitrequest), 32'd0);
        check("oor_wr_cs", 32'(mem_chipselect), 32'(exp_cs_oor));
        check("oor_wr_memwr", 32'(mem_write), 32'(exp_cs_oor));
        step();
        idle();
        m0_read = 1; m0_address = 17'd80000;
        @(negedge clk);
        check("oor_rd_cs", 32'(mem_chipselect), 32'(exp_cs_oor));
        step();
        idle();
        @(negedge clk);
        check("oor_rd_rdv", 32'(m0_readdatavalid), 32'd1);
        check("oor_rd_data", m0_readdata, exp_oor_data);

        // Build up DMA run count, then reset during a DMA read acceptance
        step();
        m0_read = 1; m0_address = 17'h10;
        m1_read = 1; m1_address = 17'd5;
        step();
        step();
        reset = 1;
        @(negedge clk);
        check("rst_acc_m0_wait", 32'(m0_waitrequest), 32'd1);
        check("rst_acc_m1_wait", 32'(m1_waitrequest), 32'd1);
        check("rst_acc_cs", 32'(mem_chipselect), 32'd0);
        step();
        reset = 0;
        idle();
        @(negedge clk);
        check("rst_acc_m1_rdv", 32'(m1_readdatavalid), 32'd0);
        check("rst_acc_m0_rdv", 32'(m0_readdatavalid), 32'd0);
        check("rst_acc_run_cnt", 32'(dut.r_run_cnt), 32'd0);
        step();
        // Run count restarted from zero: full D,D,D,D,C pattern again
        m0_read = 1; m0_address = 17'h10;
        m1_read = 1; m1_address = 17'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_m0_wait_%0d", i), 32'(m0_waitrequest), 32'(exp_dma_seq2[4-i]));
            step();
        end
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
